// File: rtl/arb8_rr_ctrl_pkg.sv
// Shared types and constants for the eight-way grant controller.
package arb8_rr_ctrl_pkg;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
    id_to_onehot     = '0;
    id_to_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/arb8_rr_ctrl_prio_enc8.sv
// 8-to-3 priority encoder: index of the highest set bit plus a valid flag.
module prio_enc8
  import arb8_rr_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] vec,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (vec[i]) idx = IDW'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/arb8_rr_ctrl.sv
// Eight-requester grant controller with registered one-hot grant and hold limit.
// Define ARB_RR_EN for round-robin selection; otherwise highest index wins.
module arb8_rr_ctrl
  import arb8_rr_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy
);

  localparam int            CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

  state_t          state_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [IDW-1:0]  id_reg;
  logic            busy_reg;
  logic [CW-1:0]   hold_cnt_reg;
  logic [IDW-1:0]  last_reg;

  logic [NREQ-1:0] enc_in;
  logic [IDW-1:0]  enc_idx;
  logic            enc_valid;
  logic [IDW-1:0]  win_id;
  logic            release_now;

`ifdef ARB_RR_EN
  // Rotate so the search start sits at bit 0, then reverse so the lowest
  // position in search order becomes the highest index for the encoder.
  logic [IDW-1:0] start;
  assign start = last_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rr_map
      assign enc_in[NREQ-1-gi] = req[start + IDW'(gi)];
    end
  endgenerate

  assign win_id = start + (IDW'(NREQ - 1) - enc_idx);
`else
  assign enc_in = req;
  assign win_id = enc_idx;

  // last is still recorded in fixed-priority builds but never steers selection.
  logic last_unused;
  assign last_unused = ^last_reg;
`endif

  prio_enc8 u_prio_enc8 (
    .vec   (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign release_now = done || !req[id_reg] ||
                       ((hold_cnt_reg == HOLD_MAX) && en && |(req & ~gnt_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      id_reg       <= '0;
      busy_reg     <= 1'b0;
      hold_cnt_reg <= '0;
      last_reg     <= IDW'(NREQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (en && enc_valid) begin
            state_reg    <= BUSY;
            gnt_reg      <= id_to_onehot(win_id);
            id_reg       <= win_id;
            busy_reg     <= 1'b1;
            hold_cnt_reg <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            id_reg       <= '0;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            last_reg     <= id_reg;
          end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = id_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// Directed bench for arb8_rr_ctrl (MAX_HOLD=4); expectations follow ARB_RR_EN.
module tb_arb8_rr_ctrl;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  arb8_rr_ctrl #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                         input logic eb);
    $display("[%0t] %s req=%h en=%b done=%b -> gnt=%h id=%0d busy=%b",
             $time, tag, req, en, done, gnt, gnt_id, busy);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  function automatic logic [7:0] oh(input logic [2:0] id);
    logic [7:0] v;
    v = 8'h01 << id;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] seq_exp [4];
  logic [2:0] e;

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'hFF; done = 1'b0;
    #1;
    chk_out("reset_t0", 8'h00, 3'd0, 1'b0);
    step();
    chk_out("reset_edge", 8'h00, 3'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("idle_en0", 8'h00, 3'd0, 1'b0);
    end

    // Constant two-sided request, done pulsed on every grant
    req = 8'b1000_0011; en = 1'b1;
    if (RR) begin
      seq_exp[0] = 3'd0; seq_exp[1] = 3'd1; seq_exp[2] = 3'd7; seq_exp[3] = 3'd0;
    end else begin
      seq_exp[0] = 3'd7; seq_exp[1] = 3'd7; seq_exp[2] = 3'd7; seq_exp[3] = 3'd7;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("seq_grant%0d", i), oh(seq_exp[i]), seq_exp[i], 1'b1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk_out($sformatf("seq_bubble%0d", i), 8'h00, 3'd0, 1'b0);
    end
    req = 8'h00;
    step();
    chk_out("seq_idle", 8'h00, 3'd0, 1'b0);

    // Fixed-priority pattern, done then regrant after one bubble
    req = 8'b0010_0110;
    e = RR ? 3'd1 : 3'd5;
    step();
    chk_out("pat_grant", oh(e), e, 1'b1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_out("pat_done", 8'h00, 3'd0, 1'b0);
    e = RR ? 3'd2 : 3'd5;
    step();
    chk_out("pat_regrant", oh(e), e, 1'b1);
    req = 8'h00;
    step();
    chk_out("pat_drop", 8'h00, 3'd0, 1'b0);

    // Owner 3 drops its request while 6 waits
    req = 8'h08;
    step();
    chk_out("drop_grant3", 8'h08, 3'd3, 1'b1);
    req = 8'h40;
    step();
    chk_out("drop_release", 8'h00, 3'd0, 1'b0);
    step();
    chk_out("drop_grant6", 8'h40, 3'd6, 1'b1);
    req = 8'h00;
    step();
    step();
    chk_out("drop_idle", 8'h00, 3'd0, 1'b0);

    // Preemption after exactly four cycles
    req = 8'h04;
    step();
    chk_out("pre_hold0", 8'h04, 3'd2, 1'b1);
    req = 8'h24;
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out($sformatf("pre_hold%0d", i), 8'h04, 3'd2, 1'b1);
    end
    step();
    chk_out("pre_release", 8'h00, 3'd0, 1'b0);
    step();
    chk_out("pre_grant5", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    step();
    step();
    chk_out("pre_idle", 8'h00, 3'd0, 1'b0);

    // Same contention with en low: no preemption until en returns
    req = 8'h04;
    step();
    chk_out("noen_grant2", 8'h04, 3'd2, 1'b1);
    en = 1'b0; req = 8'h24;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("noen_hold%0d", i), 8'h04, 3'd2, 1'b1);
    end
    en = 1'b1;
    step();
    chk_out("noen_release", 8'h00, 3'd0, 1'b0);
    step();
    chk_out("noen_grant5", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    step();
    step();

    // done while idle is ignored
    done = 1'b1;
    step();
    done = 1'b0;
    chk_out("idle_done", 8'h00, 3'd0, 1'b0);

    // Asynchronous reset mid-grant
    req = 8'h10;
    step();
    chk_out("ar_grant4", 8'h10, 3'd4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h81;
    e = RR ? 3'd0 : 3'd7;
    step();
    chk_out("ar_first", oh(e), e, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
